// File: rtl/wshb_arb_pkg.sv
// wshb_arbiter shared types and constants.
// States, CTI codes and requester indices.
package wshb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GNT_VGA,
    GNT_MIRE,
    GAP
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic REQ_VGA  = 1'b0;
  localparam logic REQ_MIRE = 1'b1;

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 bus bundle.
// Master drives the request, slave answers.
interface wshb_if #(
  parameter int DATA_BYTES = 4
) ();

  logic                      cyc;
  logic                      stb;
  logic                      we;
  logic [31:0]               adr;
  logic [8*DATA_BYTES-1:0]   dat_ms;
  logic [8*DATA_BYTES-1:0]   dat_sm;
  logic [DATA_BYTES-1:0]     sel;
  logic [2:0]                cti;
  logic [1:0]                bte;
  logic                      ack;
  logic                      err;
  logic                      rty;

  modport master (
    output cyc, stb, we, adr, dat_ms, sel, cti, bte,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
    output dat_sm, ack, err, rty
  );

endinterface

// File: rtl/wshb_arbiter.sv
// Two-master Wishbone arbiter for the SDRAM port.
// Round-robin with a hold limit, switch only at transfer ends.
module wshb_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int MAX_HOLD = 64
) (
  input  logic   sys_clk,
  input  logic   sys_rst,
  wshb_if.slave  wshb_ifs_vga,
  wshb_if.slave  wshb_ifs_mire,
  wshb_if.master wshb_ifm
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);

  arb_state_t    state_q, state_d;
  logic          last_gnt_q, last_gnt_d;
  logic          pend_q, pend_d;
  logic [HW-1:0] hold_cnt;
  logic          term;
  logic          preempt;
  logic          req_v, req_m;
  logic          in_gnt, enter_gnt;

  assign req_v = wshb_ifs_vga.cyc;
  assign req_m = wshb_ifs_mire.cyc;
  assign term  = wshb_ifm.ack | wshb_ifm.err | wshb_ifm.rty;

  assign in_gnt = (state_q == GNT_VGA) ||
                  (state_q == GNT_MIRE);
  assign enter_gnt = (state_d != state_q) &&
                     ((state_d == GNT_VGA) ||
                      (state_d == GNT_MIRE));

  // Holder must yield once its budget is spent and
  // the other side waits; >= so a late request is
  // still served after the counter saturated.
  always_comb begin
    preempt = 1'b0;
    case (state_q)
      GNT_VGA:  preempt = req_m && (hold_cnt >= HOLD_LAST);
      GNT_MIRE: preempt = req_v && (hold_cnt >= HOLD_LAST);
      default:  preempt = 1'b0;
    endcase
  end

  // Next-state and round-robin bookkeeping.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    pend_d     = pend_q;
    case (state_q)
      IDLE: begin
        if (req_v && req_m)
          state_d = (last_gnt_q == REQ_MIRE) ?
                    GNT_VGA : GNT_MIRE;
        else if (req_v)
          state_d = GNT_VGA;
        else if (req_m)
          state_d = GNT_MIRE;
      end
      GNT_VGA: begin
        if (!req_v) begin
          state_d    = IDLE;
          last_gnt_d = REQ_VGA;
        end else if (preempt && term) begin
          state_d    = GAP;
          pend_d     = REQ_MIRE;
          last_gnt_d = REQ_VGA;
        end
      end
      GNT_MIRE: begin
        if (!req_m) begin
          state_d    = IDLE;
          last_gnt_d = REQ_MIRE;
        end else if (preempt && term) begin
          state_d    = GAP;
          pend_d     = REQ_VGA;
          last_gnt_d = REQ_MIRE;
        end
      end
      GAP: begin
        if (pend_q == REQ_VGA)
          state_d = req_v ? GNT_VGA : IDLE;
        else
          state_d = req_m ? GNT_MIRE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset lets VGA win the first tie.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      last_gnt_q <= REQ_MIRE;
      pend_q     <= REQ_VGA;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      pend_q     <= pend_d;
    end
  end

  // Saturating count of terminated transfers per grant.
  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      hold_cnt <= '0;
    else if (enter_gnt)
      hold_cnt <= '0;
    else if (in_gnt && term && hold_cnt != HOLD_MAX)
      hold_cnt <= hold_cnt + HW'(1);
  end

  assign wshb_ifs_vga.dat_sm  = wshb_ifm.dat_sm;
  assign wshb_ifs_mire.dat_sm = wshb_ifm.dat_sm;

  // Zero-latency forwarding mux keyed on the owner.
  always_comb begin
    wshb_ifm.cyc        = 1'b0;
    wshb_ifm.stb        = 1'b0;
    wshb_ifm.we         = 1'b0;
    wshb_ifm.adr        = '0;
    wshb_ifm.dat_ms     = '0;
    wshb_ifm.sel        = '0;
    wshb_ifm.cti        = CTI_CLASSIC;
    wshb_ifm.bte        = '0;
    wshb_ifs_vga.ack    = 1'b0;
    wshb_ifs_vga.err    = 1'b0;
    wshb_ifs_vga.rty    = 1'b0;
    wshb_ifs_mire.ack   = 1'b0;
    wshb_ifs_mire.err   = 1'b0;
    wshb_ifs_mire.rty   = 1'b0;
    case (state_q)
      GNT_VGA: begin
        wshb_ifm.cyc      = wshb_ifs_vga.cyc;
        wshb_ifm.stb      = wshb_ifs_vga.stb;
        wshb_ifm.we       = wshb_ifs_vga.we;
        wshb_ifm.adr      = wshb_ifs_vga.adr;
        wshb_ifm.dat_ms   = wshb_ifs_vga.dat_ms;
        wshb_ifm.sel      = wshb_ifs_vga.sel;
        wshb_ifm.bte      = wshb_ifs_vga.bte;
        wshb_ifm.cti      = preempt ? CTI_EOB :
                            wshb_ifs_vga.cti;
        wshb_ifs_vga.ack  = wshb_ifm.ack;
        wshb_ifs_vga.err  = wshb_ifm.err;
        wshb_ifs_vga.rty  = wshb_ifm.rty;
      end
      GNT_MIRE: begin
        wshb_ifm.cyc      = wshb_ifs_mire.cyc;
        wshb_ifm.stb      = wshb_ifs_mire.stb;
        wshb_ifm.we       = wshb_ifs_mire.we;
        wshb_ifm.adr      = wshb_ifs_mire.adr;
        wshb_ifm.dat_ms   = wshb_ifs_mire.dat_ms;
        wshb_ifm.sel      = wshb_ifs_mire.sel;
        wshb_ifm.bte      = wshb_ifs_mire.bte;
        wshb_ifm.cti      = preempt ? CTI_EOB :
                            wshb_ifs_mire.cti;
        wshb_ifs_mire.ack = wshb_ifm.ack;
        wshb_ifs_mire.err = wshb_ifm.err;
        wshb_ifs_mire.rty = wshb_ifm.rty;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed bench for wshb_arbiter with MAX_HOLD=4.
// SDRAM model acks 2 cycles after a strobe.
module tb_wshb_arbiter;
  import wshb_arb_pkg::*;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;

  always #5 sys_clk = ~sys_clk;

  wshb_if #(.DATA_BYTES(4)) vga_if ();
  wshb_if #(.DATA_BYTES(4)) mire_if ();
  wshb_if #(.DATA_BYTES(4)) sd_if ();

  wshb_arbiter #(.MAX_HOLD(4)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .wshb_ifs_vga  (vga_if),
    .wshb_ifs_mire (mire_if),
    .wshb_ifm      (sd_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string tag,
                       logic [31:0] got,
                       logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  int cyc_n = 0;
  always @(posedge sys_clk) cyc_n <= cyc_n + 1;

  // SDRAM slave model
  int sd_cnt;
  int sd_terms;
  int err_at = 0;

  assign sd_if.rty    = 1'b0;
  assign sd_if.dat_sm = ~sd_if.adr;

  always @(posedge sys_clk) begin
    if (sys_rst) begin
      sd_cnt    <= 0;
      sd_terms  <= 0;
      sd_if.ack <= 1'b0;
      sd_if.err <= 1'b0;
    end else if (sd_if.ack || sd_if.err) begin
      sd_if.ack <= 1'b0;
      sd_if.err <= 1'b0;
      sd_cnt    <= 0;
    end else if (sd_if.cyc && sd_if.stb) begin
      if (sd_cnt == 1) begin
        sd_cnt   <= 0;
        sd_terms <= sd_terms + 1;
        if (sd_terms + 1 == err_at)
          sd_if.err <= 1'b1;
        else
          sd_if.ack <= 1'b1;
      end else begin
        sd_cnt <= sd_cnt + 1;
      end
    end else begin
      sd_cnt <= 0;
    end
  end

  // master control and observation state
  int vga_left = 0, mire_left = 0;
  int vga_acks, mire_acks, vga_errs, mire_errs;
  int vga_req_cyc, vga_drop_cyc;
  int rise_cyc, fall_cyc;
  int last_owner, idle_run, n_own;
  int first_owner, second_owner, idle_between;
  int dead_bad, fwd_bad, fwd_n;
  int last_vga_ack_cyc, gap_from_ack;
  logic [2:0] cti_first, cti4;
  logic prev_cyc;

  task automatic clr_mon();
    vga_acks = 0; mire_acks = 0;
    vga_errs = 0; mire_errs = 0;
    vga_req_cyc = -1; vga_drop_cyc = -1;
    rise_cyc = -1; fall_cyc = -1;
    last_owner = 0; idle_run = 0; n_own = 0;
    first_owner = 0; second_owner = 0;
    idle_between = -1; dead_bad = 0;
    fwd_bad = 0; fwd_n = 0;
    last_vga_ack_cyc = -100; gap_from_ack = -1;
    cti_first = 3'bx; cti4 = 3'bx;
    prev_cyc = 1'b0;
  endtask

  // monitor first, then both masters update
  always @(negedge sys_clk) begin
    int owner;
    int n;
    owner = sd_if.cyc ? int'(sd_if.adr[31:28]) : 0;
    if (sd_if.cyc === 1'b1 && !prev_cyc)
      rise_cyc = cyc_n;
    if (sd_if.cyc === 1'b0 && prev_cyc)
      fall_cyc = cyc_n;
    prev_cyc = (sd_if.cyc === 1'b1);
    if (owner == 0) begin
      idle_run++;
    end else begin
      if (owner != last_owner) begin
        if (last_owner != 0 && idle_run == 0)
          dead_bad++;
        n_own++;
        if (n_own == 1) first_owner = owner;
        if (n_own == 2) begin
          second_owner = owner;
          idle_between = idle_run;
        end
        if (owner == 2 && gap_from_ack < 0)
          gap_from_ack = cyc_n - last_vga_ack_cyc;
        last_owner = owner;
      end
      idle_run = 0;
    end
    if (owner == 2 && sd_if.stb) begin
      fwd_n++;
      if (sd_if.we !== mire_if.we ||
          sd_if.adr !== mire_if.adr ||
          sd_if.dat_ms !== mire_if.dat_ms ||
          sd_if.sel !== mire_if.sel)
        fwd_bad++;
    end
    if (vga_if.ack === 1'b1) begin
      if (vga_acks == 0) cti_first = sd_if.cti;
      if (vga_acks == 3) cti4 = sd_if.cti;
      vga_acks++;
      last_vga_ack_cyc = cyc_n;
      if (vga_left > 0) vga_left--;
    end
    if (vga_if.err === 1'b1) begin
      vga_errs++;
      if (vga_left > 0) vga_left--;
    end
    if (mire_if.ack === 1'b1) begin
      mire_acks++;
      if (mire_left > 0) mire_left--;
    end
    if (mire_if.err === 1'b1) begin
      mire_errs++;
      if (mire_left > 0) mire_left--;
    end
    if (vga_left > 0) begin
      if (vga_if.cyc !== 1'b1) vga_req_cyc = cyc_n;
      vga_if.cyc = 1'b1;
      vga_if.stb = 1'b1;
      vga_if.adr = 32'h1000_0000 + 32'(vga_acks * 4);
    end else begin
      if (vga_if.cyc === 1'b1) vga_drop_cyc = cyc_n;
      vga_if.cyc = 1'b0;
      vga_if.stb = 1'b0;
      vga_if.adr = 32'h1000_0000;
    end
    vga_if.we     = 1'b0;
    vga_if.cti    = CTI_INCR;
    vga_if.bte    = 2'b00;
    vga_if.sel    = 4'hf;
    vga_if.dat_ms = '0;
    n = mire_acks + mire_errs;
    mire_if.cyc    = (mire_left > 0);
    mire_if.stb    = (mire_left > 0);
    mire_if.we     = 1'b1;
    mire_if.adr    = 32'h2000_0000 + 32'(n * 4);
    mire_if.dat_ms = 32'ha5a5_0000 + 32'(n);
    mire_if.sel    = 4'hf ^ 4'(n);
    mire_if.cti    = CTI_CLASSIC;
    mire_if.bte    = 2'b00;
  end

  task automatic do_reset();
    sys_rst = 1'b1;
    vga_left = 0;
    mire_left = 0;
    repeat (3) @(posedge sys_clk);
    #1;
    clr_mon();
    sys_rst = 1'b0;
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  int acks_before;
  int vga_at_mire;

  initial begin
    clr_mon();
    tick(3);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    check("rst_hold", 32'(dut.hold_cnt), 0);
    check("rst_last", 32'(dut.last_gnt_q), 32'(REQ_MIRE));
    check("rst_cyc", 32'(sd_if.cyc), 0);
    sys_rst = 1'b0;
    clr_mon();

    // VGA alone, 4 reads
    vga_left = 4;
    for (int i = 0; i < 100 && vga_left > 0; i++) tick(1);
    tick(3);
    check("t1_done", 32'(vga_left), 0);
    check("t1_vga_acks", 32'(vga_acks), 4);
    check("t1_mire_acks", 32'(mire_acks), 0);
    check("t1_rise", 32'(rise_cyc - vga_req_cyc), 1);
    check("t1_fall", 32'(fall_cyc - vga_drop_cyc), 1);
    check("t1_cti", 32'(cti_first), 32'(CTI_INCR));

    // VGA alone streaming: counter saturates
    do_reset();
    vga_left = 1000;
    for (int i = 0; i < 100 && vga_acks < 6; i++) tick(1);
    check("sat_hold", 32'(dut.hold_cnt), 4);
    check("sat_state", 32'(dut.state_q), 32'(GNT_VGA));
    vga_left = 0;
    tick(4);

    // tie after reset
    do_reset();
    vga_left = 2;
    mire_left = 2;
    for (int i = 0; i < 200 &&
         (vga_left > 0 || mire_left > 0); i++) tick(1);
    tick(3);
    check("t2_first", 32'(first_owner), 1);
    check("t2_second", 32'(second_owner), 2);
    check("t2_idle", 32'(idle_between), 1);
    check("t2_dead", 32'(dead_bad), 0);

    // preemption of a VGA burst
    do_reset();
    vga_left = 1000;
    mire_left = 2;
    for (int i = 0; i < 300 && mire_left > 0; i++) tick(1);
    vga_at_mire = vga_acks;
    check("t3_vga_at_mire", 32'(vga_at_mire), 4);
    check("t3_mire_acks", 32'(mire_acks), 2);
    check("t3_cti_first", 32'(cti_first), 32'(CTI_INCR));
    check("t3_cti_eob", 32'(cti4), 32'(CTI_EOB));
    check("t3_gap_idle", 32'(idle_between), 1);
    check("t3_ack_to_stb", 32'(gap_from_ack), 2);
    for (int i = 0; i < 50 && vga_acks < 5; i++) tick(1);
    check("t3_vga_back", 32'(vga_acks > 4), 1);
    check("t3_dead", 32'(dead_bad), 0);
    vga_left = 0;
    tick(4);

    // mire writes 3 words, err on the 2nd
    do_reset();
    err_at = 2;
    mire_left = 3;
    for (int i = 0; i < 100 && mire_left > 0; i++) tick(1);
    tick(3);
    err_at = 0;
    check("t4_mire_acks", 32'(mire_acks), 2);
    check("t4_mire_errs", 32'(mire_errs), 1);
    check("t4_vga_acks", 32'(vga_acks), 0);
    check("t4_vga_errs", 32'(vga_errs), 0);
    check("t4_fwd_bad", 32'(fwd_bad), 0);
    check("t4_fwd_n", 32'(fwd_n), 9);

    // mire drops during GAP
    do_reset();
    vga_left = 1000;
    mire_left = 1000;
    for (int i = 0; i < 100 && vga_acks < 4; i++) tick(1);
    check("t5_gap", 32'(dut.state_q), 32'(GAP));
    mire_left = 0;
    tick(1);
    check("t5_idle", 32'(dut.state_q), 32'(IDLE));
    tick(1);
    check("t5_regrant", 32'(dut.state_q), 32'(GNT_VGA));
    check("t5_mire_acks", 32'(mire_acks), 0);
    vga_left = 0;
    tick(4);

    // reset while mire is mid-transfer
    do_reset();
    mire_left = 1000;
    for (int i = 0; i < 100 && mire_acks < 2; i++) tick(1);
    for (int i = 0; i < 20 &&
         !(dut.state_q == GNT_MIRE && sd_if.stb &&
           sd_cnt == 0 && !sd_if.ack); i++) tick(1);
    check("t6_pre_hold", 32'(dut.hold_cnt), 2);
    acks_before = mire_acks;
    sys_rst = 1'b1;
    tick(1);
    check("t6_cyc", 32'(sd_if.cyc), 0);
    check("t6_state", 32'(dut.state_q), 32'(IDLE));
    check("t6_hold", 32'(dut.hold_cnt), 0);
    vga_left = 2;
    tick(2);
    check("t6_no_ack", 32'(mire_acks), 32'(acks_before));
    clr_mon();
    sys_rst = 1'b0;
    for (int i = 0; i < 100 && vga_left > 0; i++) tick(1);
    check("t6_tie_vga", 32'(first_owner), 1);
    mire_left = 0;
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

endmodule
